// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush controller for the five-stage LC-3b pipeline.
// Handles load-use hazards, D-cache stalls, I-cache misses and MEM-resolved
// redirects. A redirect that arrives while a fetch is outstanding is parked in
// target_q (state PEND) and is applied when that fetch returns.
// Optional feature: define HAZARD_PERF_EN to build the stall/bubble counters.

package lc3b_types;
   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;
   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;
endpackage

module hazard_control_unit
   import lc3b_types::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       imem_resp,
   input  logic       dmem_req,
   input  logic       dmem_resp,
   input  lc3b_opcode opcode_EX,
   input  logic       regwrite_EX,
   input  lc3b_reg    destreg_EX,
   input  lc3b_reg    sr1_ID,
   input  lc3b_reg    sr2_ID,
   input  logic       sr1_used_ID,
   input  logic       sr2_used_ID,
   input  logic       br_taken_MEM,
   input  lc3b_word   br_target_MEM,
   output logic       load_pc,
   output logic       load_ifid,
   output logic       load_idex,
   output logic       load_exmem,
   output logic       load_memwb,
   output logic       flush_ifid,
   output logic       flush_idex,
   output logic       flush_exmem,
   output logic       redirect_valid,
   output lc3b_word   redirect_pc,
   output logic [15:0] stall_count,
   output logic [15:0] bubble_count
);

   typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

   state_e   state_q, state_d;
   lc3b_word target_q, target_d;
   logic     is_load_EX, ldu, mem_hold;

   // Hazard detection: load in EX feeding a live ID source, and D-cache hold.
   always_comb begin
      is_load_EX = (opcode_EX == op_ldr) || (opcode_EX == op_ldb) ||
                   (opcode_EX == op_ldi);
      ldu        = regwrite_EX && is_load_EX &&
                   ((sr1_used_ID && (sr1_ID == destreg_EX)) ||
                    (sr2_used_ID && (sr2_ID == destreg_EX)));
      mem_hold   = dmem_req && !dmem_resp;
   end

   // Priority-ordered load/flush/redirect decode and next-state logic.
   always_comb begin
      load_pc        = 1'b1;
      load_ifid      = 1'b1;
      load_idex      = 1'b1;
      load_exmem     = 1'b1;
      load_memwb     = 1'b1;
      flush_ifid     = 1'b0;
      flush_idex     = 1'b0;
      flush_exmem    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      state_d        = state_q;
      target_d       = target_q;

      if (reset) begin
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
         flush_exmem = 1'b1;
         state_d     = RUN;
         target_d    = '0;
      end else if (mem_hold) begin
         // Freeze everything; a branch in MEM waits for its access to finish.
         load_pc    = 1'b0;
         load_ifid  = 1'b0;
         load_idex  = 1'b0;
         load_exmem = 1'b0;
         load_memwb = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (br_taken_MEM) begin
                  flush_ifid  = 1'b1;
                  flush_idex  = 1'b1;
                  flush_exmem = 1'b1;
                  if (imem_resp) begin
                     redirect_valid = 1'b1;
                     redirect_pc    = br_target_MEM;
                  end else begin
                     // Fetch in flight: the cache must see a stable address,
                     // so park the target until the response arrives.
                     load_pc  = 1'b0;
                     target_d = br_target_MEM;
                     state_d  = PEND;
                  end
               end else if (ldu) begin
                  // One bubble; IF/ID keeps its instruction even on an I-miss.
                  load_pc    = 1'b0;
                  load_ifid  = 1'b0;
                  flush_idex = 1'b1;
               end else if (!imem_resp) begin
                  load_pc    = 1'b0;
                  flush_ifid = 1'b1;
               end
            end
            PEND: begin
               // Wrong-path fetch returning now is discarded via flush_ifid.
               load_pc    = imem_resp;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
               if (imem_resp) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = target_q;
                  state_d        = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State and pending-target registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_count_q, stall_count_d;
   logic [15:0] bubble_count_q, bubble_count_d;

   // Saturating stall and bubble counters.
   always_comb begin
      stall_count_d  = stall_count_q;
      bubble_count_d = bubble_count_q;
      if (!load_pc && (stall_count_q != 16'hFFFF))
         stall_count_d = stall_count_q + 16'd1;
      if (load_idex && flush_idex && (bubble_count_q != 16'hFFFF))
         bubble_count_d = bubble_count_q + 16'd1;
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q  <= '0;
         bubble_count_q <= '0;
      end else begin
         stall_count_q  <= stall_count_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   assign stall_count  = stall_count_q;
   assign bubble_count = bubble_count_q;
`else
   assign stall_count  = '0;
   assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Table-driven bench for hazard_control_unit. Each table entry is one clock
// cycle of inputs plus the expected combinational outputs for that cycle.
// Counter expectations are accumulated from the expected outputs.

module tb_hazard_control_unit;
   import lc3b_types::*;

   logic       clk;
   logic       reset, imem_resp, dmem_req, dmem_resp;
   lc3b_opcode opcode_EX;
   logic       regwrite_EX;
   lc3b_reg    destreg_EX, sr1_ID, sr2_ID;
   logic       sr1_used_ID, sr2_used_ID, br_taken_MEM;
   lc3b_word   br_target_MEM;
   logic       load_pc, load_ifid, load_idex, load_exmem, load_memwb;
   logic       flush_ifid, flush_idex, flush_exmem, redirect_valid;
   lc3b_word   redirect_pc;
   logic [15:0] stall_count, bubble_count;

   hazard_control_unit dut (
      .clk(clk), .reset(reset), .imem_resp(imem_resp),
      .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .opcode_EX(opcode_EX), .regwrite_EX(regwrite_EX),
      .destreg_EX(destreg_EX), .sr1_ID(sr1_ID), .sr2_ID(sr2_ID),
      .sr1_used_ID(sr1_used_ID), .sr2_used_ID(sr2_used_ID),
      .br_taken_MEM(br_taken_MEM), .br_target_MEM(br_target_MEM),
      .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
      .load_exmem(load_exmem), .load_memwb(load_memwb),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .flush_exmem(flush_exmem), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall_count(stall_count),
      .bubble_count(bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, imem, dreq, dresp;
      lc3b_opcode op;
      logic       rw;
      lc3b_reg    dst, s1, s2;
      logic       s1u, s2u, br;
      lc3b_word   tgt;
      logic [4:0] ld;   // {pc, ifid, idex, exmem, memwb}
      logic [2:0] fl;   // {ifid, idex, exmem}
      logic       rv;
      lc3b_word   rpc;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   logic [15:0] exp_stall = '0, exp_bubble = '0;
   logic        cnt_known = 1'b0;

   function automatic vec_t idle();
      vec_t v;
      v.rst = 1'b0; v.imem = 1'b1; v.dreq = 1'b0; v.dresp = 1'b0;
      v.op = op_add; v.rw = 1'b0; v.dst = 3'd0; v.s1 = 3'd0; v.s2 = 3'd0;
      v.s1u = 1'b0; v.s2u = 1'b0; v.br = 1'b0; v.tgt = 16'h0000;
      v.ld = 5'b11111; v.fl = 3'b000; v.rv = 1'b0; v.rpc = 16'h0000;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL vec%0d %s got %h expected %h", idx, name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int idx);
      @(negedge clk);
      reset = v.rst; imem_resp = v.imem; dmem_req = v.dreq; dmem_resp = v.dresp;
      opcode_EX = v.op; regwrite_EX = v.rw; destreg_EX = v.dst;
      sr1_ID = v.s1; sr2_ID = v.s2; sr1_used_ID = v.s1u; sr2_used_ID = v.s2u;
      br_taken_MEM = v.br; br_target_MEM = v.tgt;
      #2;
      check("loads", idx,
            {27'd0, load_pc, load_ifid, load_idex, load_exmem, load_memwb},
            {27'd0, v.ld});
      check("flushes", idx, {29'd0, flush_ifid, flush_idex, flush_exmem},
            {29'd0, v.fl});
      check("redirect_valid", idx, {31'd0, redirect_valid}, {31'd0, v.rv});
      check("redirect_pc", idx, {16'd0, redirect_pc}, {16'd0, v.rpc});
      if (cnt_known) begin
`ifdef HAZARD_PERF_EN
         check("stall_count", idx, {16'd0, stall_count}, {16'd0, exp_stall});
         check("bubble_count", idx, {16'd0, bubble_count}, {16'd0, exp_bubble});
`else
         check("stall_count", idx, {16'd0, stall_count}, 32'd0);
         check("bubble_count", idx, {16'd0, bubble_count}, 32'd0);
`endif
      end
      // Counter model for the edge that ends this cycle.
      if (v.rst) begin
         exp_stall  = '0;
         exp_bubble = '0;
         cnt_known  = 1'b1;
      end else begin
         if (!v.ld[4] && exp_stall != 16'hFFFF) exp_stall++;
         if (v.ld[2] && v.fl[1] && exp_bubble != 16'hFFFF) exp_bubble++;
      end
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
      opcode_EX = op_add; regwrite_EX = 1'b0; destreg_EX = '0;
      sr1_ID = '0; sr2_ID = '0; sr1_used_ID = 1'b0; sr2_used_ID = 1'b0;
      br_taken_MEM = 1'b0; br_target_MEM = '0;

      // 0: reset
      v = idle(); v.rst = 1; v.fl = 3'b111; tbl.push_back(v);
      // 1: normal flow
      v = idle(); tbl.push_back(v);
      // 2: ldr R2 in EX, ID reads R2 via sr1 -> one bubble
      v = idle(); v.op = op_ldr; v.rw = 1; v.dst = 3'd2; v.s1 = 3'd2; v.s1u = 1;
      v.ld = 5'b00111; v.fl = 3'b010; tbl.push_back(v);
      // 3: bubble now in EX
      v = idle(); tbl.push_back(v);
      // 4: same register, but sr1 not actually read -> no stall
      v = idle(); v.op = op_ldr; v.rw = 1; v.dst = 3'd2; v.s1 = 3'd2; v.s1u = 0;
      tbl.push_back(v);
      // 5: ldb hazard through sr2
      v = idle(); v.op = op_ldb; v.rw = 1; v.dst = 3'd5; v.s2 = 3'd5; v.s2u = 1;
      v.ld = 5'b00111; v.fl = 3'b010; tbl.push_back(v);
      // 6: ldi matching but regwrite low -> no stall
      v = idle(); v.op = op_ldi; v.rw = 0; v.dst = 3'd3; v.s1 = 3'd3; v.s1u = 1;
      tbl.push_back(v);
      // 7: ldi hazard with I-miss: load-use wins, IF/ID held
      v = idle(); v.op = op_ldi; v.rw = 1; v.dst = 3'd3; v.s1 = 3'd3; v.s1u = 1;
      v.imem = 0; v.ld = 5'b00111; v.fl = 3'b010; tbl.push_back(v);
      // 8: add with matching regs is not a load -> only the I-miss applies
      v = idle(); v.rw = 1; v.dst = 3'd3; v.s1 = 3'd3; v.s1u = 1; v.imem = 0;
      v.ld = 5'b01111; v.fl = 3'b100; tbl.push_back(v);
      // 9-11: D-cache hold for three cycles, 12: response
      for (int i = 0; i < 3; i++) begin
         v = idle(); v.dreq = 1; v.ld = 5'b00000; tbl.push_back(v);
      end
      v = idle(); v.dreq = 1; v.dresp = 1; tbl.push_back(v);
      // 13: branch during D-cache hold is ignored
      v = idle(); v.dreq = 1; v.br = 1; v.tgt = 16'h3000; v.ld = 5'b00000;
      tbl.push_back(v);
      // 14: taken branch, fetch idle -> immediate redirect
      v = idle(); v.br = 1; v.tgt = 16'h3000; v.fl = 3'b111; v.rv = 1;
      v.rpc = 16'h3000; tbl.push_back(v);
      // 15: taken branch with fetch in flight -> PEND
      v = idle(); v.br = 1; v.tgt = 16'h4000; v.imem = 0; v.ld = 5'b01111;
      v.fl = 3'b111; tbl.push_back(v);
      // 16-18: still waiting on the fetch
      for (int i = 0; i < 3; i++) begin
         v = idle(); v.imem = 0; v.ld = 5'b01111; v.fl = 3'b110; tbl.push_back(v);
      end
      // 19: fetch returns -> redirect to parked target
      v = idle(); v.fl = 3'b110; v.rv = 1; v.rpc = 16'h4000; tbl.push_back(v);
      // 20: back in RUN
      v = idle(); tbl.push_back(v);
      // 21: PEND again, 22: D-cache hold inside PEND, 23: release
      v = idle(); v.br = 1; v.tgt = 16'h5000; v.imem = 0; v.ld = 5'b01111;
      v.fl = 3'b111; tbl.push_back(v);
      v = idle(); v.dreq = 1; v.ld = 5'b00000; tbl.push_back(v);
      v = idle(); v.fl = 3'b110; v.rv = 1; v.rpc = 16'h5000; tbl.push_back(v);
      // 24: PEND, 25: reset mid-PEND, 26-27: RUN with no stale redirect
      v = idle(); v.br = 1; v.tgt = 16'h6000; v.imem = 0; v.ld = 5'b01111;
      v.fl = 3'b111; tbl.push_back(v);
      v = idle(); v.rst = 1; v.imem = 0; v.fl = 3'b111; tbl.push_back(v);
      v = idle(); v.imem = 0; v.ld = 5'b01111; v.fl = 3'b100; tbl.push_back(v);
      v = idle(); tbl.push_back(v);

      foreach (tbl[i]) step(tbl[i], i);

      // Hand sequence: back-to-back redirect with miss, then load-use after
      // return, finishing with a counter read after a further reset.
      v = idle(); v.br = 1; v.tgt = 16'hBEEF; v.imem = 0; v.ld = 5'b01111;
      v.fl = 3'b111; step(v, 100);
      v = idle(); v.fl = 3'b110; v.rv = 1; v.rpc = 16'hBEEF; step(v, 101);
      v = idle(); v.op = op_ldr; v.rw = 1; v.dst = 3'd7; v.s2 = 3'd7; v.s2u = 1;
      v.ld = 5'b00111; v.fl = 3'b010; step(v, 102);
      v = idle(); step(v, 103);
      v = idle(); v.rst = 1; v.fl = 3'b111; step(v, 104);
      v = idle(); step(v, 105);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
